// File: rtl/mac_stats_collector_if.sv
// Stream taps, event pulses and snapshot/readout bundle for mac_stats_collector.
// The master side drives the taps; the slave side is the collector.
interface mac_stats_collector_if #(
  parameter int AXIS_DATA_BYTES = 4,
  parameter int CNT_WIDTH       = 32
);
  logic [AXIS_DATA_BYTES-1:0] tx_axis_tkeep;
  logic                       tx_axis_tvalid;
  logic                       tx_axis_tready;
  logic                       tx_axis_tlast;
  logic [AXIS_DATA_BYTES-1:0] rx_axis_tkeep;
  logic                       rx_axis_tvalid;
  logic                       rx_axis_tready;
  logic                       rx_axis_tlast;
  logic                       rx_frame_error;
  logic                       rx_crc_error;
  logic                       snapshot_req;
  logic                       clear_on_snapshot;
  logic [3:0]                 rd_addr;
  logic [CNT_WIDTH-1:0]       rd_data;
  logic                       snapshot_done;

  modport master (
    output tx_axis_tkeep, tx_axis_tvalid,
    output tx_axis_tready, tx_axis_tlast,
    output rx_axis_tkeep, rx_axis_tvalid,
    output rx_axis_tready, rx_axis_tlast,
    output rx_frame_error, rx_crc_error,
    output snapshot_req, clear_on_snapshot,
    output rd_addr,
    input  rd_data, snapshot_done
  );

  modport slave (
    input  tx_axis_tkeep, tx_axis_tvalid,
    input  tx_axis_tready, tx_axis_tlast,
    input  rx_axis_tkeep, rx_axis_tvalid,
    input  rx_axis_tready, rx_axis_tlast,
    input  rx_frame_error, rx_crc_error,
    input  snapshot_req, clear_on_snapshot,
    input  rd_addr,
    output rd_data, snapshot_done
  );
endinterface

// File: rtl/mac_stats_collector.sv
// Passive TX/RX AXIS statistics with RX size histogram and shadow snapshot.
// Define MAC_STATS_SATURATE_EN to make live counters saturate instead of wrap.
module mac_stats_collector #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int CNT_WIDTH       = 32,
  parameter int FRAME_LEN_WIDTH = 16
) (
  input logic                  mac_clk,
  input logic                  mac_rst,
  mac_stats_collector_if.slave bus
);

  localparam int NCNT = 14;
  localparam int LW   = FRAME_LEN_WIDTH + 16;

  localparam int TX_FRAMES = 0;
  localparam int TX_BYTES  = 1;
  localparam int RX_FRAMES = 2;
  localparam int RX_BYTES  = 3;
  localparam int RX_ERR    = 4;
  localparam int RX_CRC    = 5;
  localparam int RX_UNDER  = 6;
  localparam int RX_64     = 7;
  localparam int RX_65     = 8;
  localparam int RX_128    = 9;
  localparam int RX_256    = 10;
  localparam int RX_512    = 11;
  localparam int RX_1024   = 12;
  localparam int RX_OVER   = 13;

  typedef logic [CNT_WIDTH-1:0]       cnt_t;
  typedef logic [FRAME_LEN_WIDTH-1:0] len_t;

  function automatic logic [7:0] popcnt(
    input logic [AXIS_DATA_BYTES-1:0] k
  );
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < AXIS_DATA_BYTES; i++)
      n = n + 8'(k[i]);
    return n;
  endfunction

  function automatic cnt_t cnt_add(
    input cnt_t       a,
    input logic [7:0] b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
`ifdef MAC_STATS_SATURATE_EN
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
`else
    return s[CNT_WIDTH-1:0];
`endif
  endfunction

  // Length accumulators always saturate so huge frames land in oversize.
  function automatic len_t len_add(
    input len_t       a,
    input logic [7:0] b
  );
    logic [FRAME_LEN_WIDTH:0] s;
    s = {1'b0, a} + (FRAME_LEN_WIDTH+1)'(b);
    return s[FRAME_LEN_WIDTH] ? '1 : s[FRAME_LEN_WIDTH-1:0];
  endfunction

  cnt_t cnt_q    [NCNT];
  cnt_t cnt_d    [NCNT];
  cnt_t shadow_q [NCNT];
  cnt_t shadow_d [NCNT];
  len_t tx_acc_q, tx_acc_d;
  len_t rx_acc_q, rx_acc_d;
  cnt_t rd_data_q, rd_data_d;
  logic done_q, done_d;

  logic [7:0]  inc [NCNT];
  logic        tx_beat, rx_beat;
  logic        tx_eof, rx_eof;
  logic [7:0]  tx_n, rx_n;
  len_t        tx_len, rx_len;
  logic [LW-1:0] rx_ext;
  logic        rx_sat, clr;
  logic        b_und, b_64, b_65, b_128;
  logic        b_256, b_512, b_1024, b_ovr;

  always_comb begin
    tx_beat = bus.tx_axis_tvalid & bus.tx_axis_tready;
    rx_beat = bus.rx_axis_tvalid & bus.rx_axis_tready;
    tx_eof  = tx_beat & bus.tx_axis_tlast;
    rx_eof  = rx_beat & bus.rx_axis_tlast;
    tx_n    = tx_beat ? popcnt(bus.tx_axis_tkeep) : 8'd0;
    rx_n    = rx_beat ? popcnt(bus.rx_axis_tkeep) : 8'd0;

    tx_len  = len_add(tx_acc_q, tx_n);
    rx_len  = len_add(rx_acc_q, rx_n);
    rx_sat  = (rx_len == '1);
    rx_ext  = LW'(rx_len);

    tx_acc_d = tx_acc_q;
    if (tx_beat)
      tx_acc_d = bus.tx_axis_tlast ? '0 : tx_len;
    rx_acc_d = rx_acc_q;
    if (rx_beat)
      rx_acc_d = bus.rx_axis_tlast ? '0 : rx_len;

    b_und  = ~rx_sat & (rx_ext <  LW'(64));
    b_64   = ~rx_sat & (rx_ext == LW'(64));
    b_65   = ~rx_sat & (rx_ext >= LW'(65))
           & (rx_ext <= LW'(127));
    b_128  = ~rx_sat & (rx_ext >= LW'(128))
           & (rx_ext <= LW'(255));
    b_256  = ~rx_sat & (rx_ext >= LW'(256))
           & (rx_ext <= LW'(511));
    b_512  = ~rx_sat & (rx_ext >= LW'(512))
           & (rx_ext <= LW'(1023));
    b_1024 = ~rx_sat & (rx_ext >= LW'(1024))
           & (rx_ext <= LW'(1518));
    b_ovr  = rx_sat | (rx_ext > LW'(1518));

    inc[TX_FRAMES] = 8'(tx_eof);
    inc[TX_BYTES]  = tx_n;
    inc[RX_FRAMES] = 8'(rx_eof);
    inc[RX_BYTES]  = rx_n;
    inc[RX_ERR]    = 8'(bus.rx_frame_error);
    inc[RX_CRC]    = 8'(bus.rx_crc_error);
    inc[RX_UNDER]  = 8'(rx_eof & b_und);
    inc[RX_64]     = 8'(rx_eof & b_64);
    inc[RX_65]     = 8'(rx_eof & b_65);
    inc[RX_128]    = 8'(rx_eof & b_128);
    inc[RX_256]    = 8'(rx_eof & b_256);
    inc[RX_512]    = 8'(rx_eof & b_512);
    inc[RX_1024]   = 8'(rx_eof & b_1024);
    inc[RX_OVER]   = 8'(rx_eof & b_ovr);

    // A clearing capture still keeps this cycle's events.
    clr = bus.snapshot_req & bus.clear_on_snapshot;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i]    = cnt_add(clr ? '0 : cnt_q[i], inc[i]);
      shadow_d[i] = bus.snapshot_req ? cnt_q[i]
                                     : shadow_q[i];
    end

    rd_data_d = '0;
    if (bus.rd_addr < 4'(NCNT))
      rd_data_d = bus.snapshot_req ? cnt_q[bus.rd_addr]
                                   : shadow_q[bus.rd_addr];
    done_d = bus.snapshot_req;
  end

  always_ff @(posedge mac_clk) begin
    if (!mac_rst) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      tx_acc_q  <= '0;
      rx_acc_q  <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      tx_acc_q  <= tx_acc_d;
      rx_acc_q  <= rx_acc_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.snapshot_done = done_q;

endmodule

// File: tb/tb_mac_stats_collector.sv
// Scoreboard bench for mac_stats_collector (32-bit stream, 16-bit counters).
// Read expectations are queued by stimulus and popped by a separate monitor.
module tb_mac_stats_collector;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic mac_rst;
  always #5 clk = ~clk;

  mac_stats_collector_if #(
    .AXIS_DATA_BYTES(4), .CNT_WIDTH(CW)
  ) bus ();

  mac_stats_collector #(
    .AXIS_DATA_WIDTH(32), .AXIS_DATA_BYTES(4),
    .CNT_WIDTH(CW), .FRAME_LEN_WIDTH(16)
  ) dut (
    .mac_clk(clk),
    .mac_rst(mac_rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] exp_q  [$];
  logic [3:0]    addr_q [$];
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;
  logic snap_d = 1'b0;

`ifdef MAC_STATS_SATURATE_EN
  localparam logic [CW-1:0] BIG_BYTES  = 16'd65535;
  localparam logic [CW-1:0] WRAP_CNT   = 16'd65535;
`else
  localparam logic [CW-1:0] BIG_BYTES  = 16'd464;
  localparam logic [CW-1:0] WRAP_CNT   = 16'd1;
`endif

  always @(posedge clk) begin
    rd_req_d <= rd_req;
    snap_d   <= bus.snapshot_req;
  end

  // Monitor: compares rd_data and snapshot_done one cycle after the request.
  always @(negedge clk) begin
    logic [CW-1:0] e;
    logic [3:0]    a;
    if (rd_req_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: read with no expectation");
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_addr_%0d: got %0d expected %0d",
                   a, bus.rd_data, e);
        end
      end
    end
    if (snap_d || bus.snapshot_done) begin
      checks++;
      if (bus.snapshot_done !== snap_d) begin
        errors++;
        $display("FAIL snapshot_done: got %0b expected %0b",
                 bus.snapshot_done, snap_d);
      end
    end
  end

  task automatic rd(input logic [3:0] a, input logic [CW-1:0] e);
    bus.rd_addr = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic snap(input bit clr);
    bus.snapshot_req = 1'b1;
    bus.clear_on_snapshot = clr;
    @(negedge clk);
    bus.snapshot_req = 1'b0;
    bus.clear_on_snapshot = 1'b0;
  endtask

  // Capture and read in the same cycle: data must be the fresh capture.
  task automatic snap_rd(input bit clr, input logic [3:0] a,
                         input logic [CW-1:0] e);
    bus.rd_addr = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    snap(clr);
    rd_req = 1'b0;
  endtask

  task automatic beat(input bit rx, input logic [3:0] k,
                      input bit l, input bit rdy = 1'b1);
    if (rx) begin
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tready = rdy;
      bus.rx_axis_tkeep  = k;
      bus.rx_axis_tlast  = l;
    end else begin
      bus.tx_axis_tvalid = 1'b1;
      bus.tx_axis_tready = rdy;
      bus.tx_axis_tkeep  = k;
      bus.tx_axis_tlast  = l;
    end
    @(negedge clk);
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tready = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    bus.tx_axis_tvalid = 1'b0;
    bus.tx_axis_tready = 1'b0;
    bus.tx_axis_tlast  = 1'b0;
  endtask

  task automatic rx_frame(input int len);
    int n;
    int r;
    logic [3:0] k;
    n = (len + 3) / 4;
    r = len % 4;
    for (int i = 0; i < n; i++) begin
      k = 4'hf;
      if (i == n - 1 && r != 0) k = 4'((1 << r) - 1);
      beat(1'b1, k, i == n - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mac_rst = 1'b0;
    bus.tx_axis_tkeep = '0;
    bus.tx_axis_tvalid = 1'b0;
    bus.tx_axis_tready = 1'b0;
    bus.tx_axis_tlast = 1'b0;
    bus.rx_axis_tkeep = '0;
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tready = 1'b0;
    bus.rx_axis_tlast = 1'b0;
    bus.rx_frame_error = 1'b0;
    bus.rx_crc_error = 1'b0;
    bus.snapshot_req = 1'b0;
    bus.clear_on_snapshot = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    mac_rst = 1'b1;

    rd(4'd0, 0); rd(4'd1, 0); rd(4'd13, 0);

    // Valid without ready on both streams: nothing counts.
    for (int i = 0; i < 10; i++) begin
      bus.tx_axis_tvalid = 1'b1;
      bus.tx_axis_tkeep  = 4'hf;
      bus.tx_axis_tlast  = 1'b1;
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tkeep  = 4'hf;
      bus.rx_axis_tlast  = 1'b1;
      @(negedge clk);
    end
    bus.tx_axis_tvalid = 1'b0;
    bus.rx_axis_tvalid = 1'b0;
    bus.tx_axis_tlast  = 1'b0;
    bus.rx_axis_tlast  = 1'b0;

    // 16-beat TX frame ending in 2 bytes: 62 bytes.
    for (int i = 0; i < 15; i++) beat(1'b0, 4'hf, 1'b0);
    beat(1'b0, 4'b0011, 1'b1);
    snap(1'b1);
    rd(4'd0, 1); rd(4'd1, 62); rd(4'd2, 0); rd(4'd3, 0);

    rx_frame(60); rx_frame(64); rx_frame(1518); rx_frame(1600);
    snap(1'b1);
    rd(4'd2, 4);  rd(4'd3, 3242);
    rd(4'd6, 1);  rd(4'd7, 1);  rd(4'd8, 0);  rd(4'd9, 0);
    rd(4'd10, 0); rd(4'd11, 0); rd(4'd12, 1); rd(4'd13, 1);
    rd(4'd14, 0); rd(4'd0, 0);

    // Sparse tkeep with a stalled beat: 4+0+2+1 = 7 bytes.
    beat(1'b1, 4'hf, 1'b0);
    beat(1'b1, 4'hf, 1'b1, 1'b0);
    beat(1'b1, 4'b0000, 1'b0);
    beat(1'b1, 4'b1010, 1'b0);
    beat(1'b1, 4'b0001, 1'b1);
    rx_frame(100); rx_frame(200); rx_frame(300); rx_frame(600);
    beat(1'b1, 4'b0100, 1'b1);
    snap(1'b1);
    rd(4'd2, 6);  rd(4'd3, 1208);
    rd(4'd6, 2);  rd(4'd7, 0);  rd(4'd8, 1);  rd(4'd9, 1);
    rd(4'd10, 1); rd(4'd11, 1); rd(4'd12, 0); rd(4'd13, 0);

    // Error pulses, including both in the capture cycle.
    bus.rx_frame_error = 1'b1; @(negedge clk);
    bus.rx_frame_error = 1'b0; bus.rx_crc_error = 1'b1;
    @(negedge clk);
    bus.rx_frame_error = 1'b1; @(negedge clk);
    snap_rd(1'b1, 4'd4, 2);
    bus.rx_frame_error = 1'b0; bus.rx_crc_error = 1'b0;
    rd(4'd5, 2);
    snap_rd(1'b1, 4'd4, 1);
    snap_rd(1'b1, 4'd5, 0);
    rd(4'd4, 0);

    // Reset mid-frame after 20 bytes, then 44 more with tlast.
    for (int i = 0; i < 5; i++) beat(1'b1, 4'hf, 1'b0);
    mac_rst = 1'b0; @(negedge clk); mac_rst = 1'b1;
    for (int i = 0; i < 11; i++) beat(1'b1, 4'hf, i == 10);
    snap(1'b1);
    rd(4'd2, 1); rd(4'd3, 44); rd(4'd6, 1); rd(4'd7, 0);

    // 66000-byte frame saturates the length accumulator.
    for (int i = 0; i < 16500; i++) beat(1'b1, 4'hf, i == 16499);
    snap(1'b1);
    rd(4'd2, 1); rd(4'd3, BIG_BYTES);
    rd(4'd13, 1); rd(4'd12, 0); rd(4'd10, 0);

    // 65537 one-byte single-beat frames overflow 16-bit counters.
    for (int i = 0; i < 65537; i++) beat(1'b1, 4'b0001, 1'b1);
    snap(1'b1);
    rd(4'd2, WRAP_CNT); rd(4'd3, WRAP_CNT);
    rd(4'd6, WRAP_CNT); rd(4'd13, 0);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads unchecked, expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
